seven_seg_scanner_bcd: RTL and testbench
========================================

Name: seven_seg_scanner_bcd

Overview:
Parametrised multiplexed seven-segment driver for N digits. It replaces combinational divide/modulo digit extraction with a serial double-dabble binary-to-BCD converter, and adds a hex mode, leading-zero blanking, per-digit decimal points and overflow indication. It sits between the datapath register to be shown and the board anode/cathode pins.

Parameters:
DIGITS, 4, number of digits/anodes (2..8, need not be a power of 2)
VALUE_W, 16, width of input binary value (4..32)
REFRESH_BITS, 18, digit dwell = 2^REFRESH_BITS clock cycles (2.6 ms at 100 MHz)

Ports:
clock_100Mhz  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0)
value  in  VALUE_W  binary number to display
load  in  1  single-cycle request to capture value/hex_mode/blank_lz/dp_in
hex_mode  in  1  1 = show hex nibbles, 0 = show decimal
blank_lz  in  1  1 = blank leading zeros
dp_in  in  DIGITS  decimal-point enables, bit k = digit k (k=0 least significant)
busy  out  1  conversion in progress; load ignored while high
overflow  out  1  decimal value >= 10^DIGITS (sticky until next accepted load)
Anode_Activate  out  DIGITS  active-low anode enables, bit k = digit k
LED_out  out  7  active-low cathodes {a,b,c,d,e,f,g}
dp_out  out  1  active-low decimal point of the active digit

Behaviour:
- Reset (reset==0 at clock edge): Anode_Activate all 1, LED_out 7'b1111111, dp_out 1, busy 0, overflow 0, digit/dp/mode registers 0, scan index DIGITS-1, refresh counter 0. Reset mid-conversion aborts it; the display shows value 0.
- Load is accepted only when busy==0 and load==1. Value, hex_mode, blank_lz and dp_in are captured. Load while busy is dropped, with no queueing.
- Hex accept at edge t: busy=1 for one cycle (t+1). Digit registers = value nibbles; nibbles above VALUE_W are 0. The overflow flag is set if any value bits lie above bit 4*DIGITS-1. Commit happens at edge t+2.
- Decimal accept at edge t: FSM IDLE->CONVERT. busy is high for VALUE_W cycles (t+1..t+VALUE_W), one double-dabble step per cycle: add 3 to each BCD nibble >=5, then shift left one bit from the value MSB. A 1 shifted out of the top nibble sets the internal overflow flag. After the last shift the FSM goes to COMMIT: digit registers and overflow update atomically, busy falls, then IDLE. The displayed digits never show partial results.
- Scan: a counter of REFRESH_BITS bits. On wrap, the scan index steps DIGITS-1 -> ... -> 0 -> DIGITS-1 (explicit wrap; not power-of-2 dependent).
- Outputs are registered, one cycle after the index change. Exactly one Anode_Activate bit is low, at the scan index.
- Glyph selection, in priority order:
  - overflow: dash 7'b1111110
  - blanked: 7'b1111111
  - otherwise digit glyph. Encodings: 0..9 = 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Hex A..F = 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Blanking: digit k > 0 is blanked iff blank_lz and all digits >= k are 0. Digit 0 is never blanked.
- dp_out = ~dp_reg[k], suppressed (1) when overflow.
- Width: the BCD shift register is 4*DIGITS bits. The bit counter is clog2(VALUE_W+1) bits.

Decomposition:
- Package seven_seg_pkg holds: the glyph constants (digits 0-F, GLYPH_BLANK, GLYPH_DASH), the FSM state encoding (IDLE, CONVERT, COMMIT), and a nibble_to_glyph function.
- Sub-module bin2bcd_serial (parameters VALUE_W, DIGITS) holds the double-dabble FSM. It has a start/done/busy handshake and bcd and overflow outputs. The top level contains the hex path, capture registers, scan counter and output registers.

Test Plan (REFRESH_BITS=2 for simulation, DIGITS=4, VALUE_W=16):
- Reset low for 3 cycles -> Anode_Activate=1111, LED_out=1111111, busy=0. After release, the first lit digit is bit 3 with LED_out=0000001.
- Decimal load 1234 -> busy high exactly 16 cycles. Scan then gives anode 0111/1001111, 1011/0010010, 1101/0000110, 1110/1001100; overflow=0.
- hex_mode=1, load 16'hBEEF -> busy high 1 cycle. Glyphs 1100000, 0110000, 0110000, 0111000.
- Decimal load 12345 -> overflow=1; all four digits 1111110; dp_out=1 even with dp_in=1111.
- blank_lz=1, load 7 -> digits 3..1 show 1111111 and digit 0 shows 0001111. Load 0 -> only digit 0 lit, showing 0000001.
- Load 9999, second load 1 on cycle 5 of busy -> the second load is ignored and 9999 is displayed. Then reset low during a conversion of 500 -> busy=0 next edge, display shows 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared glyph constants, converter state encoding and nibble-to-glyph lookup
// for the multiplexed seven-segment scanner.
package seven_seg_pkg;

  // Active-low cathodes ordered {a,b,c,d,e,f,g}
  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b1100000;
  localparam logic [6:0] GLYPH_C     = 7'b0110001;
  localparam logic [6:0] GLYPH_D     = 7'b1000010;
  localparam logic [6:0] GLYPH_E     = 7'b0110000;
  localparam logic [6:0] GLYPH_F     = 7'b0111000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } conv_state_e;

  function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_bcd_bin2bcd.sv
// Serial double-dabble converter: one add-3/shift step per cycle, VALUE_W steps.
// state   | meaning
// IDLE    | waiting for start_i
// CONVERT | shifting value bits into the BCD register, busy_o high
// COMMIT  | result was handed off with done_o on the last shift
module bin2bcd_serial
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [VALUE_W-1:0]  value_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                overflow_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  conv_state_e        state_q, state_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   adj, step_bcd;
  logic               ovf_q, ovf_d, step_ovf;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    step_bcd = {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
    // Any 1 leaving the top nibble means the value needs more digits than we have
    step_ovf = ovf_q | adj[BCD_W-1];
  end

  // The final step result is presented combinationally so the caller commits it
  // on the same edge busy falls.
  assign bcd_o      = step_bcd;
  assign overflow_o = step_ovf;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE, COMMIT: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = CONVERT;
          bin_d   = value_i;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(VALUE_W);
        end
      end
      CONVERT: begin
        busy_o = 1'b1;
        bin_d  = {bin_q[VALUE_W-2:0], 1'b0};
        bcd_d  = step_bcd;
        ovf_d  = step_ovf;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done_o  = 1'b1;
          state_d = COMMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seven_seg_scanner_bcd.sv
// Multiplexed N-digit seven-segment driver: capture, hex/decimal commit,
// leading-zero blanking, decimal points, overflow dash and anode scanning.
module seven_seg_scanner_bcd
  import seven_seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int VALUE_W      = 16,
  parameter int REFRESH_BITS = 18
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               hex_mode,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_in,
  output logic               busy,
  output logic               overflow,
  output logic [DIGITS-1:0]  Anode_Activate,
  output logic [6:0]         LED_out,
  output logic               dp_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int EXT_W = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;

  logic                    accept, start_dec;
  logic                    cvt_busy, cvt_done, cvt_ovf;
  logic [BCD_W-1:0]        cvt_bcd;

  logic [VALUE_W-1:0]      value_q;
  logic                    hex_busy_q;
  logic                    pend_blank_q;
  logic [DIGITS-1:0]       pend_dp_q;
  logic [BCD_W-1:0]        digits_q;
  logic                    ovf_q, blank_q;
  logic [DIGITS-1:0]       dp_q;

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0]       anode_q;
  logic [6:0]              led_q;
  logic                    dpo_q;

  logic [EXT_W-1:0]        value_ext;
  logic                    hex_ovf;
  logic [3:0]              cur_nib;
  logic                    cur_dp, upper_zero;
  logic [6:0]              glyph;

  assign busy      = hex_busy_q | cvt_busy;
  assign accept    = load & ~busy;
  assign start_dec = accept & ~hex_mode;

  bin2bcd_serial #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_bin2bcd (
    .clk_i      (clock_100Mhz),
    .rst_ni     (reset),
    .start_i    (start_dec),
    .value_i    (value),
    .busy_o     (cvt_busy),
    .done_o     (cvt_done),
    .bcd_o      (cvt_bcd),
    .overflow_o (cvt_ovf)
  );

  assign value_ext = EXT_W'(value_q);
  assign hex_ovf   = (value_ext >> BCD_W) != '0;

  // Display state (digits, overflow, blanking, dp) only changes at commit so
  // a conversion in flight never shows partial results.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      value_q      <= '0;
      hex_busy_q   <= 1'b0;
      pend_blank_q <= 1'b0;
      pend_dp_q    <= '0;
      digits_q     <= '0;
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
      dp_q         <= '0;
    end else begin
      hex_busy_q <= accept & hex_mode;
      if (accept) begin
        value_q      <= value;
        pend_blank_q <= blank_lz;
        pend_dp_q    <= dp_in;
      end
      if (cvt_done) begin
        digits_q <= cvt_bcd;
        ovf_q    <= cvt_ovf;
        blank_q  <= pend_blank_q;
        dp_q     <= pend_dp_q;
      end else if (hex_busy_q) begin
        digits_q <= value_ext[BCD_W-1:0];
        ovf_q    <= hex_ovf;
        blank_q  <= pend_blank_q;
        dp_q     <= pend_dp_q;
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (refresh_q == '1) begin
      idx_d = (idx_q == '0) ? IDX_W'(DIGITS - 1) : idx_q - IDX_W'(1);
    end
  end

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == int'(idx_q)) begin
        cur_nib = digits_q[4*k +: 4];
        cur_dp  = dp_q[k];
      end
      if (k >= int'(idx_q) && digits_q[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (ovf_q)                                    glyph = GLYPH_DASH;
    else if (blank_q && idx_q != '0 && upper_zero) glyph = GLYPH_BLANK;
    else                                           glyph = nibble_to_glyph(cur_nib);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      refresh_q <= '0;
      idx_q     <= IDX_W'(DIGITS - 1);
      anode_q   <= '1;
      led_q     <= GLYPH_BLANK;
      dpo_q     <= 1'b1;
    end else begin
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      idx_q     <= idx_d;
      anode_q   <= ~(DIGITS'(1) << idx_q);
      led_q     <= glyph;
      dpo_q     <= ovf_q | ~cur_dp;
    end
  end

  assign overflow       = ovf_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;
  assign dp_out         = dpo_q;

endmodule

// File: tb/tb_seven_seg_scanner_bcd.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// directed scenarios with literal expected glyphs and busy durations.
module tb_seven_seg_scanner_bcd;

  localparam int D = 4;
  localparam int W = 16;
  localparam int R = 2;

  localparam logic [6:0] GLYPHS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] value;
  logic         load, hex_mode, blank_lz;
  logic [D-1:0] dp_in;
  logic         busy, overflow;
  logic [D-1:0] an;
  logic [6:0]   led;
  logic         dp_o;

  seven_seg_scanner_bcd #(.DIGITS(D), .VALUE_W(W), .REFRESH_BITS(R)) dut (
    .clock_100Mhz   (clk),
    .reset          (rst_n),
    .value          (value),
    .load           (load),
    .hex_mode       (hex_mode),
    .blank_lz       (blank_lz),
    .dp_in          (dp_in),
    .busy           (busy),
    .overflow       (overflow),
    .Anode_Activate (an),
    .LED_out        (led),
    .dp_out         (dp_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint pow_of(input int base, input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p = p * base;
    return p;
  endfunction

  function automatic logic [6:0] exp_glyph(input longint v, input bit hx, input bit blz,
                                           input bit ov, input int k);
    int     base;
    longint p;
    base = hx ? 16 : 10;
    p    = pow_of(base, k);
    if (ov) return 7'b1111110;
    if (blz && k > 0 && v < p) return 7'b1111111;
    return GLYPHS[int'((v / p) % base)];
  endfunction

  bit           m_valid = 1'b0;
  int           m_tick, m_busy_cnt, m_idx;
  longint       m_val, p_val;
  bit           m_hex, m_blank, m_ovf, p_hex, p_blank;
  logic [D-1:0] m_dp, p_dp;
  logic [D-1:0] e_an;
  logic [6:0]   e_led;
  logic         e_dp;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      e_an = '1; e_led = 7'b1111111; e_dp = 1'b1;
      m_val = 0; m_hex = 0; m_blank = 0; m_ovf = 0; m_dp = '0;
      m_tick = 0; m_busy_cnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_idx = D - 1 - ((m_tick >> R) % D);
      e_an = '1;
      e_an[m_idx] = 1'b0;
      e_led = exp_glyph(m_val, m_hex, m_blank, m_ovf, m_idx);
      e_dp  = m_ovf ? 1'b1 : ~m_dp[m_idx];
      m_tick++;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_val = p_val; m_hex = p_hex; m_blank = p_blank; m_dp = p_dp;
          m_ovf = p_val >= pow_of(p_hex ? 16 : 10, D);
        end
      end else if (load === 1'b1) begin
        p_val = longint'(value); p_hex = hex_mode; p_blank = blank_lz; p_dp = dp_in;
        m_busy_cnt = hex_mode ? 1 : W;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy",     32'(busy),     32'(m_busy_cnt > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("anode",    32'(an),       32'(e_an));
      chk("led",      32'(led),      32'(e_led));
      chk("dp_out",   32'(dp_o),     32'(e_dp));
    end
  end

  // ---------------- directed helpers ----------------
  logic [6:0] seen_led [D];
  logic       seen_dp  [D];

  task automatic start_load(input logic [W-1:0] v, input bit hx, input bit blz,
                            input logic [D-1:0] dp);
    value = v; hex_mode = hx; blank_lz = blz; dp_in = dp; load = 1'b1;
  endtask

  task automatic load_and_time(input logic [W-1:0] v, input bit hx, input bit blz,
                               input logic [D-1:0] dp, output int n);
    @(negedge clk); #1;
    start_load(v, hx, blz, dp);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      n++;
      #1 load = 1'b0;
    end
    #1 load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic scan_capture();
    for (int k = 0; k < D; k++) begin
      seen_led[k] = 'x;
      seen_dp[k]  = 1'bx;
    end
    @(negedge clk);
    for (int i = 0; i < D * (1 << R) + 2; i++) begin
      @(negedge clk);
      for (int k = 0; k < D; k++) begin
        if (an == ~(D'(1) << k)) begin
          seen_led[k] = led;
          seen_dp[k]  = dp_o;
        end
      end
    end
    #1;
  endtask

  task automatic check_leds(input string nm, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    chk({nm, "_d3"}, 32'(seen_led[3]), 32'(e3));
    chk({nm, "_d2"}, 32'(seen_led[2]), 32'(e2));
    chk({nm, "_d1"}, 32'(seen_led[1]), 32'(e1));
    chk({nm, "_d0"}, 32'(seen_led[0]), 32'(e0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int           n, sel, gap;
    logic [W-1:0] rv;

    rst_n = 1'b0; value = '0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0; dp_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(an),   32'hF);
    chk("rst_led",   32'(led),  32'h7F);
    chk("rst_busy",  32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_anode", 32'(an),  32'(4'b0111));
    chk("first_led",   32'(led), 32'(7'b0000001));
    #1;

    load_and_time(16'd1234, 1'b0, 1'b0, 4'b0101, n);
    chk("busy_len_dec", 32'(n), 32'd16);
    wait_idle();
    scan_capture();
    check_leds("dec1234", 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
    chk("dec1234_ovf", 32'(overflow), 32'd0);
    chk("dec1234_dp0", 32'(seen_dp[0]), 32'd0);
    chk("dec1234_dp1", 32'(seen_dp[1]), 32'd1);

    load_and_time(16'hBEEF, 1'b1, 1'b0, 4'b0000, n);
    chk("busy_len_hex", 32'(n), 32'd1);
    wait_idle();
    scan_capture();
    check_leds("hexBEEF", 7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000);

    load_and_time(16'd12345, 1'b0, 1'b0, 4'b1111, n);
    wait_idle();
    scan_capture();
    chk("ovf_12345", 32'(overflow), 32'd1);
    check_leds("ovf12345", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110);
    for (int k = 0; k < D; k++) chk("ovf_dp_suppressed", 32'(seen_dp[k]), 32'd1);

    load_and_time(16'd7, 1'b0, 1'b1, 4'b0000, n);
    wait_idle();
    scan_capture();
    chk("blank7_ovf_cleared", 32'(overflow), 32'd0);
    check_leds("blank7", 7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111);

    load_and_time(16'd0, 1'b0, 1'b1, 4'b0000, n);
    wait_idle();
    scan_capture();
    check_leds("blank0", 7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001);

    @(negedge clk); #1;
    start_load(16'd9999, 1'b0, 1'b0, 4'b0000);
    @(negedge clk); #1 load = 1'b0;
    repeat (4) @(negedge clk);
    #1 start_load(16'd1, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    chk("busy_during_drop", 32'(busy), 32'd1);
    #1 load = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("drop_no_restart", 32'(busy), 32'd0);
    scan_capture();
    check_leds("keep9999", 7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100);

    @(negedge clk); #1;
    start_load(16'd500, 1'b0, 1'b0, 4'b0000);
    @(negedge clk); #1 load = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    scan_capture();
    chk("abort_ovf", 32'(overflow), 32'd0);
    check_leds("abort0", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);

    for (int it = 0; it < 250; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rv = W'($urandom_range(0, 99));
        1:       rv = W'($urandom_range(0, 9999));
        2:       rv = W'($urandom);
        default: rv = '0;
      endcase
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
      end
      start_load(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), D'($urandom));
      @(negedge clk); #1 load = 1'b0;
      gap = $urandom_range(0, 24);
      repeat (gap) @(negedge clk);
      #1;
    end
    wait_idle();
    repeat (2 * D * (1 << R)) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
